// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared opcode, controller-state and datapath-select encodings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [5:0] {
        R_TYPE = 6'b000000,
        J      = 6'b000010,
        BEQ    = 6'b000100,
        ADDI   = 6'b001000,
        LW     = 6'b100011,
        SW     = 6'b101011
    } t_opcode;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        ADDIEX = 4'd8,
        ADDIWB = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } t_mc_state;

    localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] C_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] C_PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] C_ALUSRCB_B     = 2'b00;
    localparam logic [1:0] C_ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] C_ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] C_ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
// ============================================================================
// Module  : mips_mc_ctrl
// Brief   : Multi-cycle Moore sequencer for the unified-memory MIPS datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mc_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    t_mc_state state_q;
    t_mc_state state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    LW, SW:  state_d = MEMADR;
                    R_TYPE:  state_d = EXEC;
                    ADDI:    state_d = ADDIEX;
                    BEQ:     state_d = BRANCH;
                    J:       state_d = JUMP;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: state_d = (opcode == LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            BRANCH: state_d = FETCH;
            JUMP:   state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Reset gates every strobe so nothing commits during an aborted access.
    always_comb begin
        mem_req  = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        PCSrc    = C_PCSRC_ALU;
        ALUSrcA  = 1'b0;
        ALUSrcB  = C_ALUSRCB_B;
        ALUOp    = C_ALUOP_ADD;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        retire   = 1'b0;
        illegal  = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    ALUSrcB = C_ALUSRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    ALUSrcB = C_ALUSRCB_IMMSH;
                    case (opcode)
                        LW, SW, R_TYPE, ADDI, BEQ, J: illegal = 1'b0;
                        default:                      illegal = 1'b1;
                    endcase
                end
                MEMADR, ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = C_ALUSRCB_IMM;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                MEMWR: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemWrite = mem_ready;
                    retire   = mem_ready;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = C_ALUOP_FUNCT;
                end
                ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                ADDIWB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = C_ALUOP_SUB;
                    PCSrc   = C_PCSRC_ALUOUT;
                    Branch  = 1'b1;
                    retire  = 1'b1;
                end
                JUMP: begin
                    PCSrc   = C_PCSRC_JUMP;
                    PCWrite = 1'b1;
                    retire  = 1'b1;
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

    assign state = state_q;

endmodule

`default_nettype wire
